boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_if.sv | 25 ++
 rtl/boot_loader.sv | 107 ++++++++++
 tb/tb_boot_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream intake and instruction-memory write bus of the boot loader.
// The byte source/observer uses master; the loader uses slave.
interface boot_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              error;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Loads a LEN-prefixed little-endian word stream into imem, then releases the core; 5 cycles/word + 2 for LEN.
// Backpressure: rx_ready drops during the write cycle and stays low once done or rejected.
module boot_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input logic         clk,
    input logic         rst,
    boot_loader_if.slave bus
);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      len;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic             accept;
    logic [15:0]      len_in;
    logic [15:0]      idx_inc;

    assign accept  = bus.rx_valid & bus.rx_ready;
    assign len_in  = {bus.rx_data, len[7:0]};
    assign idx_inc = 16'(word_idx) + 16'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            LEN_LO: if (accept) state_nxt = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_in == 16'd0)
                        state_nxt = DONE;
                    else if (32'(len_in) > 32'(MAX_WORDS))
                        state_nxt = ERR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA:   if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            WRITE:  state_nxt = (idx_inc == len) ? DONE : DATA;
            DONE:   state_nxt = DONE;
            ERR:    state_nxt = ERR;
            default: state_nxt = LEN_LO;
        endcase
    end

    // Handshake and status outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= LEN_LO;
            len            <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            word_buf       <= '0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.core_rst_n <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.rx_ready   <= (state_nxt == LEN_LO) || (state_nxt == LEN_HI) || (state_nxt == DATA);
            bus.imem_we    <= (state_nxt == WRITE);
            bus.core_rst_n <= (state_nxt == DONE);
            bus.done       <= (state_nxt == DONE);
            bus.error      <= (state_nxt == ERR);

            if (accept) begin
                case (state)
                    LEN_LO: len[7:0]  <= bus.rx_data;
                    LEN_HI: len[15:8] <= bus.rx_data;
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            default: begin
                                bus.imem_wdata <= {bus.rx_data, word_buf};
                                bus.imem_addr  <= ADDR_W'({word_idx, 2'b00});
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            if (state == WRITE) begin
                word_idx <= word_idx + IDX_W'(1);
                byte_idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed vector table, multi-cycle corner sequences,
// and random streams compared against a stream-level reference model.
`timescale 1ns/1ps
module tb_boot_loader;
    localparam int MAX_WORDS = 1024;
    localparam int ADDR_W    = 32;

    typedef logic [7:0] bytes_t[$];

    typedef struct {
        int          n;
        logic [7:0]  b [10];
        int          mode;
        bit          e_done;
        bit          e_err;
        int          nw;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    boot_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int cyc = 0;
    int first_acc = -1;
    int done_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: samples on the falling edge, where inputs and outputs are stable.
    always @(negedge clk) begin
        if (!rst) begin
            wr_addr_q.delete();
            wr_data_q.delete();
            first_acc = -1;
            done_cyc  = -1;
        end else begin
            if (bus.imem_we) begin
                wr_addr_q.push_back(32'(bus.imem_addr));
                wr_data_q.push_back(bus.imem_wdata);
            end
            if (first_acc < 0 && bus.rx_valid && bus.rx_ready) first_acc = cyc + 1;
            if (done_cyc < 0 && bus.done) done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst = 1'b0;
        #1;
        check("rst_rx_ready",   32'(bus.rx_ready),   0);
        check("rst_imem_we",    32'(bus.imem_we),    0);
        check("rst_imem_addr",  32'(bus.imem_addr),  0);
        check("rst_imem_wdata", bus.imem_wdata,      0);
        check("rst_core_rst_n", 32'(bus.core_rst_n), 0);
        check("rst_done",       32'(bus.done),       0);
        check("rst_error",      32'(bus.error),      0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rx_ready_before_edge", 32'(bus.rx_ready), 0);
        @(posedge clk);
        #2;
        check("rx_ready_first_edge", 32'(bus.rx_ready), 1);
    endtask

    // mode 0: back-to-back, 1: one byte then two idle cycles, 2: random idle gaps
    task automatic send(input bytes_t q, input int mode);
        int i = 0;
        int gap = 0;
        int budget = 10 * q.size() + 20;
        bit rdy;
        bit vld;
        while (i < q.size()) begin
            if (budget <= 0) begin
                check("send_budget_bytes_accepted", 32'(i), 32'(q.size()));
                break;
            end
            if (gap > 0) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                gap--;
            end else begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = q[i];
            end
            @(negedge clk);
            rdy = bus.rx_ready;
            vld = bus.rx_valid;
            @(posedge clk);
            #2;
            budget--;
            if (vld && rdy) begin
                i++;
                gap = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(bus.done || bus.error) && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("end_reached", 32'(bus.done || bus.error), 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Reference: LEN from the first two bytes, then each word from its four bytes, address 4*index.
    task automatic model(input bytes_t q, output bit e_done, output bit e_err, output int len);
        len = int'(q[0]) + 256 * int'(q[1]);
        exp_addr_q.delete();
        exp_data_q.delete();
        e_done = (len <= MAX_WORDS);
        e_err  = (len > MAX_WORDS);
        if (e_done) begin
            for (int w = 0; w < len; w++) begin
                exp_addr_q.push_back(32'(4 * w));
                exp_data_q.push_back(32'(q[2 + 4*w]) + 32'(q[3 + 4*w]) * 32'h100 +
                                     32'(q[4 + 4*w]) * 32'h10000 + 32'(q[5 + 4*w]) * 32'h1000000);
            end
        end
    endtask

    task automatic verify(input string tag, input bit e_done, input bit e_err, input int len, input bit chk_lat);
        int n;
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) begin
            if (wr_addr_q[i] !== exp_addr_q[i]) check({tag, "_addr"}, wr_addr_q[i], exp_addr_q[i]);
            if (wr_data_q[i] !== exp_data_q[i]) check({tag, "_data"}, wr_data_q[i], exp_data_q[i]);
        end
        check({tag, "_done"},       32'(bus.done),       32'(e_done));
        check({tag, "_error"},      32'(bus.error),      32'(e_err));
        check({tag, "_core_rst_n"}, 32'(bus.core_rst_n), 32'(e_done));
        check({tag, "_rx_ready"},   32'(bus.rx_ready),   0);
        check({tag, "_imem_we"},    32'(bus.imem_we),    0);
        // First accepted byte's edge to the edge that raises done: 1 + 5*LEN edges (2 + 5*LEN cycles inclusive).
        if (chk_lat && e_done) check({tag, "_latency"}, 32'(done_cyc - first_acc), 32'(1 + 5 * len));
    endtask

    vec_t   vt [5];
    bytes_t q;
    bit     e_done;
    bit     e_err;
    int     len;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        vt[0] = '{10, '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00},
                  0, 1'b1, 1'b0, 2, 32'h00500013, 32'h00A00093};
        vt[1] = '{2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
        vt[2] = '{2, '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vt[3] = '{6, '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00},
                  1, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0};
        vt[4] = '{2, '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 1'b0, 1'b1, 0, 32'h0, 32'h0};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            q.delete();
            for (int k = 0; k < vt[v].n; k++) q.push_back(vt[v].b[k]);
            send(q, vt[v].mode);
            wait_end();
            exp_addr_q.delete();
            exp_data_q.delete();
            if (vt[v].nw > 0) begin exp_addr_q.push_back(32'h0); exp_data_q.push_back(vt[v].d0); end
            if (vt[v].nw > 1) begin exp_addr_q.push_back(32'h4); exp_data_q.push_back(vt[v].d1); end
            verify($sformatf("vec%0d", v), vt[v].e_done, vt[v].e_err,
                   int'(vt[v].b[0]) + 256 * int'(vt[v].b[1]), vt[v].mode == 0);
        end

        // Reset in the middle of a word aborts the load; a complete fresh stream is required.
        do_reset();
        q = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        send(q, 0);
        @(negedge clk);
        check("abort_core_rst_n", 32'(bus.core_rst_n), 0);
        check("abort_nwrites",    32'(wr_addr_q.size()), 0);
        do_reset();
        q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send(q, 0);
        wait_end();
        model(q, e_done, e_err, len);
        verify("reload", e_done, e_err, len, 1'b1);

        // DONE is sticky and ignores offered bytes.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        repeat (10) @(posedge clk);
        #2;
        bus.rx_valid = 1'b0;
        check("sticky_done",    32'(bus.done),          1);
        check("sticky_nwrites", 32'(wr_addr_q.size()),  1);
        check("sticky_rx_ready", 32'(bus.rx_ready),     0);

        // A long stall mid-word holds all state.
        do_reset();
        q.delete();
        q.push_back(8'h02); q.push_back(8'h00);
        for (int k = 0; k < 8; k++) q.push_back(8'($urandom));
        model(q, e_done, e_err, len);
        send(q[0:4], 0);
        repeat (40) @(posedge clk);
        #2;
        check("stall_nwrites", 32'(wr_addr_q.size()), 0);
        check("stall_done",    32'(bus.done),         0);
        check("stall_rx_ready", 32'(bus.rx_ready),    1);
        send(q[5:9], 2);
        wait_end();
        verify("stall", e_done, e_err, len, 1'b0);

        // Random streams with random gaps, plus both LEN boundaries.
        for (int r = 0; r < 10; r++) begin
            int l;
            bit lat;
            if (r == 8)      l = MAX_WORDS;
            else if (r == 9) l = int'($urandom_range(MAX_WORDS + 1, 65535));
            else             l = int'($urandom_range(1, 12));
            lat = (r == 8);
            q.delete();
            q.push_back(8'(l));
            q.push_back(8'(l >> 8));
            if (l <= MAX_WORDS)
                for (int k = 0; k < 4 * l; k++) q.push_back(8'($urandom));
            model(q, e_done, e_err, len);
            do_reset();
            send(q, lat ? 0 : 2);
            wait_end();
            verify($sformatf("rand%0d", r), e_done, e_err, len, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
